// File: rtl/collision_scanner_pkg.sv
// Shared geometry defaults, derived block counts and scanner FSM encoding.
package collision_pkg;

    localparam int unsigned SCREEN_WIDTH_DEF    = 400;
    localparam int unsigned SCREEN_HEIGHT_DEF   = 700;
    localparam int unsigned BLOCK_WIDTH_DEF     = 40;
    localparam int unsigned BLOCK_HEIGHT_DEF    = 5;
    localparam int unsigned DOODLE_WIDTH_DEF    = 20;

    localparam int unsigned BLOCK_IN_WIDTH_DEF  = SCREEN_WIDTH_DEF / BLOCK_WIDTH_DEF;
    localparam int unsigned BLOCK_IN_HEIGHT_DEF = SCREEN_HEIGHT_DEF / BLOCK_HEIGHT_DEF;
    localparam int unsigned COUNT_BLOCKS_DEF    = BLOCK_IN_WIDTH_DEF * BLOCK_IN_HEIGHT_DEF;
    localparam int unsigned IW_DEF              = $clog2(COUNT_BLOCKS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/collision_scanner_if.sv
// Scanner bus: scan handshake plus the block-table read port (one-cycle read latency).
interface collision_scanner_if #(
    parameter int unsigned IW = collision_pkg::IW_DEF
);
    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_x;
    logic [31:0]   rd_y;
    logic          rd_active;

    modport master (
        input  start, rd_x, rd_y, rd_active,
        output busy, done, rd_idx
    );

    modport slave (
        output start, rd_x, rd_y, rd_active,
        input  busy, done, rd_idx
    );
endinterface

// File: rtl/collision_scanner_block_hit_check.sv
// Combinational doodle-foot vs platform overlap test; all sums widened to 33 bits.
module block_hit_check
    import collision_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH  = BLOCK_WIDTH_DEF,
    parameter int unsigned BLOCK_HEIGHT = BLOCK_HEIGHT_DEF,
    parameter int unsigned DOODLE_WIDTH = DOODLE_WIDTH_DEF
) (
    input  logic [31:0] doodle_x,
    input  logic [31:0] doodle_y,
    input  logic [31:0] block_x,
    input  logic [31:0] block_y,
    input  logic        active,
    input  logic        falling,
    output logic        hit
);
    logic [32:0] doodle_r;
    logic [32:0] block_r;
    logic [32:0] block_b;

    always_comb begin
        doodle_r = {1'b0, doodle_x} + 33'(DOODLE_WIDTH);
        block_r  = {1'b0, block_x} + 33'(BLOCK_WIDTH);
        block_b  = {1'b0, block_y} + 33'(BLOCK_HEIGHT);
        hit = active && falling
              && (block_y <= doodle_y) && ({1'b0, doodle_y} < block_b)
              && (doodle_r > {1'b0, block_x}) && ({1'b0, doodle_x} < block_r);
    end
endmodule

// File: rtl/collision_scanner.sv
// Sequentially scans the block table and reports the lowest-index platform hit.
// Optional COLLISION_EARLY_EXIT_EN stops the scan at the first hit.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int unsigned BLOCK_WIDTH   = BLOCK_WIDTH_DEF,
    parameter int unsigned BLOCK_HEIGHT  = BLOCK_HEIGHT_DEF,
    parameter int unsigned DOODLE_WIDTH  = DOODLE_WIDTH_DEF,
    localparam int unsigned BLOCK_IN_WIDTH  = SCREEN_WIDTH / BLOCK_WIDTH,
    localparam int unsigned BLOCK_IN_HEIGHT = SCREEN_HEIGHT / BLOCK_HEIGHT,
    localparam int unsigned COUNT_BLOCKS    = BLOCK_IN_WIDTH * BLOCK_IN_HEIGHT,
    localparam int unsigned IW              = $clog2(COUNT_BLOCKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   doodle_x,
    input  logic [31:0]   doodle_y,
    input  logic          falling,
    output logic [IW-1:0] rd_idx,
    input  logic [31:0]   rd_x,
    input  logic [31:0]   rd_y,
    input  logic          rd_active,
    output logic          busy,
    output logic          done,
    output logic          has_collide,
    output logic [31:0]   collision_x,
    output logic [31:0]   collision_y
);
    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   col_q, col_d, row_q, row_d;
    logic [31:0]   pend_col_q, pend_col_d, pend_row_q, pend_row_d;
    logic [31:0]   dx_q, dx_d, dy_q, dy_d, cx_q, cx_d, cy_q, cy_d;
    logic          pend_valid_q, pend_valid_d, fall_q, fall_d, has_q, has_d;
    logic          hit, hit_new, last_issue, early_stop;

    block_hit_check #(
        .BLOCK_WIDTH  (BLOCK_WIDTH),
        .BLOCK_HEIGHT (BLOCK_HEIGHT),
        .DOODLE_WIDTH (DOODLE_WIDTH)
    ) u_hit (
        .doodle_x (dx_q),
        .doodle_y (dy_q),
        .block_x  (rd_x),
        .block_y  (rd_y),
        .active   (rd_active),
        .falling  (fall_q),
        .hit      (hit)
    );

    // pend_* tags the read returning this cycle with the column/row it was issued for
    assign hit_new    = pend_valid_q && hit && !has_q
                        && ((state_q == ST_SCAN) || (state_q == ST_DRAIN));
    assign last_issue = (idx_q == IW'(COUNT_BLOCKS - 1));
`ifdef COLLISION_EARLY_EXIT_EN
    assign early_stop = hit_new;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pend_col_q   <= '0;
            pend_row_q   <= '0;
            pend_valid_q <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            fall_q       <= 1'b0;
            has_q        <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pend_col_q   <= pend_col_d;
            pend_row_q   <= pend_row_d;
            pend_valid_q <= pend_valid_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            fall_q       <= fall_d;
            has_q        <= has_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SCAN;
            ST_SCAN: begin
                if (early_stop)      state_d = ST_DONE;
                else if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        pend_col_d   = pend_col_q;
        pend_row_d   = pend_row_q;
        pend_valid_d = 1'b0;
        dx_d         = dx_q;
        dy_d         = dy_q;
        fall_d       = fall_q;
        has_d        = has_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dx_d   = doodle_x;
                    dy_d   = doodle_y;
                    fall_d = falling;
                    has_d  = 1'b0;
                    idx_d  = '0;
                    col_d  = '0;
                    row_d  = '0;
                end
            end
            ST_SCAN: begin
                if (!early_stop) begin
                    pend_valid_d = 1'b1;
                    pend_col_d   = col_q;
                    pend_row_d   = row_q;
                    idx_d        = idx_q + 1'b1;
                    if (row_q == 32'(BLOCK_IN_HEIGHT - 1)) begin
                        row_d = '0;
                        col_d = col_q + 32'd1;
                    end else begin
                        row_d = row_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
        if (hit_new) begin
            has_d = 1'b1;
            cx_d  = pend_col_q;
            cy_d  = pend_row_q;
        end
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        rd_idx = (state_q == ST_SCAN) ? idx_q : '0;
    end

    assign has_collide = has_q;
    assign collision_x = cx_q;
    assign collision_y = cy_q;
endmodule

// File: tb/tb_collision_scanner.sv
// Randomised and directed bench for collision_scanner against a table-walking reference model.
module tb_collision_scanner;
    import collision_pkg::*;

    localparam int BW  = 40;
    localparam int BH  = 5;
    localparam int DW  = 20;
    localparam int BIH = 140;
    localparam int N   = 1400;

    logic        clk;
    logic        reset;
    logic [31:0] doodle_x, doodle_y;
    logic        falling;
    logic        has_collide;
    logic [31:0] collision_x, collision_y;

    collision_scanner_if #(.IW(11)) bus ();

    collision_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .start       (bus.start),
        .doodle_x    (doodle_x),
        .doodle_y    (doodle_y),
        .falling     (falling),
        .rd_idx      (bus.rd_idx),
        .rd_x        (bus.rd_x),
        .rd_y        (bus.rd_y),
        .rd_active   (bus.rd_active),
        .busy        (bus.busy),
        .done        (bus.done),
        .has_collide (has_collide),
        .collision_x (collision_x),
        .collision_y (collision_y)
    );

    logic [31:0] mem_x [N];
    logic [31:0] mem_y [N];
    logic        mem_a [N];

    int checks   = 0;
    int failures = 0;

    // Expected sticky result registers
    logic        m_has;
    logic [31:0] m_cx, m_cy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block table with one-cycle read latency
    always @(posedge clk) begin
        bus.rd_x      <= mem_x[bus.rd_idx];
        bus.rd_y      <= mem_y[bus.rd_idx];
        bus.rd_active <= mem_a[bus.rd_idx];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] dx, dy, input logic f, input int i);
        longint unsigned x, y, bx, by;
        x = dx; y = dy; bx = mem_x[i]; by = mem_y[i];
        return mem_a[i] && f && (by <= y) && (y < by + BH) && (x + DW > bx) && (x < bx + BW);
    endfunction

    function automatic int first_hit(input logic [31:0] dx, dy, input logic f);
        for (int i = 0; i < N; i++)
            if (model_hit(dx, dy, f, i)) return i;
        return -1;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
            mem_a[i] = 1'b0;
        end
    endtask

    task automatic place(input int i, input logic [31:0] x, y);
        mem_x[i] = x;
        mem_y[i] = y;
        mem_a[i] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_rd_idx"}, 64'(bus.rd_idx), 64'd0);
        check({tag, "_has"}, 64'(has_collide), 64'(m_has));
        check({tag, "_cx"}, 64'(collision_x), 64'(m_cx));
        check({tag, "_cy"}, 64'(collision_y), 64'(m_cy));
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic run_scan(input string tag, input logic [31:0] dx, dy, input logic f, input bit poke);
        int exp_idx, exp_done, cyc, exp_rd;
        bit seen_done;
        exp_idx = first_hit(dx, dy, f);
`ifdef COLLISION_EARLY_EXIT_EN
        exp_done = (exp_idx >= 0) ? exp_idx + 3 : N + 2;
`else
        exp_done = N + 2;
`endif
        doodle_x = dx; doodle_y = dy; falling = f; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        doodle_x = $urandom; doodle_y = $urandom; falling = 1'(~f);
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < exp_done + 4) begin
            @(negedge clk);
            cyc++;
            if (poke) bus.start = (cyc == 100);
            exp_rd = (cyc < exp_done && cyc <= N) ? cyc - 1 : 0;
            check({tag, "_busy"}, 64'(bus.busy), 64'(cyc <= exp_done));
            check({tag, "_done"}, 64'(bus.done), 64'(cyc == exp_done));
            check({tag, "_rd_idx"}, 64'(bus.rd_idx), 64'(exp_rd));
            if (bus.done) seen_done = 1'b1;
        end
        if (!seen_done) check({tag, "_done_timeout"}, 64'(cyc), 64'(exp_done));
        m_has = (exp_idx >= 0);
        if (m_has) begin
            m_cx = 32'(exp_idx / BIH);
            m_cy = 32'(exp_idx % BIH);
        end
        check({tag, "_has"}, 64'(has_collide), 64'(m_has));
        check({tag, "_cx"}, 64'(collision_x), 64'(m_cx));
        check({tag, "_cy"}, 64'(collision_y), 64'(m_cy));
        // start during the done cycle must be ignored
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle({tag, "_post"});
        end
    endtask

    initial begin
        logic [31:0] dx, dy, rx, ry;
        logic        f;
        int          p;

        bus.start = 1'b0;
        doodle_x = '0; doodle_y = '0; falling = 1'b0;
        m_has = 1'b0; m_cx = '0; m_cy = '0;
        clear_mem();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        // Hit at idx 283 = col 2, row 3
        place(283, 32'd80, 32'd15);
        check("model_idx_283", 64'(first_hit(32'd90, 32'd17, 1'b1)), 64'd283);
        run_scan("hit283", 32'd90, 32'd17, 1'b1, 1'b0);
        check("hit283_lit_x", 64'(collision_x), 64'd2);
        check("hit283_lit_y", 64'(collision_y), 64'd3);

        // Reset mid-scan after a prior hit
        doodle_x = 32'd90; doodle_y = 32'd17; falling = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_has = 1'b0; m_cx = '0; m_cy = '0;
        check_idle("midreset");
        repeat (5) begin
            @(negedge clk);
            check_idle("midreset_after");
        end

        run_scan("nofall", 32'd90, 32'd17, 1'b0, 1'b0);
        check("nofall_lit_has", 64'(has_collide), 64'd0);

        check("model_xedge", 64'(first_hit(32'd120, 32'd17, 1'b1)), 64'hFFFF_FFFF_FFFF_FFFF);
        run_scan("xedge_right", 32'd120, 32'd17, 1'b1, 1'b0);
        check("model_xleft", 64'(first_hit(32'd61, 32'd17, 1'b1)), 64'd283);
        run_scan("xedge_left", 32'd61, 32'd17, 1'b1, 1'b0);
        run_scan("yedge", 32'd90, 32'd20, 1'b1, 1'b0);

        clear_mem();
        place(10, 32'd200, 32'd300);
        place(5, 32'd205, 32'd298);
        check("model_two_hits", 64'(first_hit(32'd210, 32'd301, 1'b1)), 64'd5);
        run_scan("two_hits", 32'd210, 32'd301, 1'b1, 1'b1);
        check("two_hits_lit_y", 64'(collision_y), 64'd5);

        clear_mem();
        place(0, 32'd0, 32'd0);
        run_scan("overflow", 32'hFFFF_FFF0, 32'd2, 1'b1, 1'b0);
        check("overflow_lit_has", 64'(has_collide), 64'd0);
        place(7, 32'hFFFF_FFE0, 32'd0);
        check("model_wide_sum", 64'(first_hit(32'hFFFF_FFF0, 32'd2, 1'b1)), 64'd7);
        run_scan("wide_sum", 32'hFFFF_FFF0, 32'd2, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = ($urandom_range(3) == 0);
                mem_x[i] = $urandom_range(399);
                mem_y[i] = $urandom_range(699);
            end
            dx = $urandom_range(399);
            dy = $urandom_range(699);
            f  = ($urandom_range(4) != 0);
            if (t % 2 == 0) begin
                p  = $urandom_range(N - 1);
                rx = dx + $urandom_range(19);
                ry = (dy >= 4) ? dy - $urandom_range(4) : dy;
                place(p, rx, ry);
            end
            run_scan("random", dx, dy, f, 1'(t % 3 == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
